// File: rtl/axis_host_driver_if.sv
// rtl/axis_host_driver_if.sv - start handshake, source read, AXIS and result-store bus bundle
interface axis_host_driver_if #(
    parameter int DATA_W = 32,
    parameter int IN_AW  = 3,
    parameter int OUT_AW = 2
);
    // accelerator start handshake
    logic              ex_start;
    logic              ex_startAck;
    // synchronous source buffer read port
    logic              src_en;
    logic [IN_AW-1:0]  src_adr;
    logic [DATA_W-1:0] src_data;
    // AXIS master (host to accelerator)
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    // AXIS slave (accelerator to host)
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    // result-store write port
    logic              res_we;
    logic [OUT_AW-1:0] res_adr;
    logic [DATA_W-1:0] res_data;

    // host driver side
    modport master (
        output ex_start,
        input  ex_startAck,
        output src_en, src_adr,
        input  src_data,
        output m_data, m_valid, m_last,
        input  m_ready,
        input  s_data, s_valid, s_last,
        output s_ready,
        output res_we, res_adr, res_data
    );

    // accelerator / memory side
    modport slave (
        input  ex_start,
        output ex_startAck,
        input  src_en, src_adr,
        output src_data,
        input  m_data, m_valid, m_last,
        output m_ready,
        output s_data, s_valid, s_last,
        input  s_ready,
        input  res_we, res_adr, res_data
    );
endinterface

// File: rtl/axis_host_driver.sv
// rtl/axis_host_driver.sv - runs one start/stream-out/collect transaction against the accelerator
module axis_host_driver #(
    parameter int DATA_W    = 32,
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 4,
    parameter int IN_AW     = 3,
    parameter int OUT_AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    output logic                busy,
    output logic                done,
    output logic                err_last,
    axis_host_driver_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, REQ, REL, FETCH, LOAD, SEND, RECV, FIN
    } state_t;

    state_t              state_q, state_d;
    logic [IN_AW-1:0]    cnt_q, cnt_d;
    logic [OUT_AW-1:0]   rcnt_q, rcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_last_q, err_last_d;
    logic                ex_start_q, ex_start_d;
    logic                src_en_q, src_en_d;
    logic [IN_AW-1:0]    src_adr_q, src_adr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic                s_ready_q, s_ready_d;
    logic                res_we_q, res_we_d;
    logic [OUT_AW-1:0]   res_adr_q, res_adr_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;

    // next-state and registered-output computation; pulses default low, everything else holds
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcnt_d     = rcnt_q;
        done_d     = 1'b0;
        err_last_d = err_last_q;
        ex_start_d = ex_start_q;
        src_en_d   = src_en_q;
        src_adr_d  = src_adr_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        s_ready_d  = s_ready_q;
        res_we_d   = 1'b0;
        res_adr_d  = res_adr_q;
        res_data_d = res_data_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = REQ;
                    ex_start_d = 1'b1;
                    err_last_d = 1'b0;
                    cnt_d      = '0;
                    rcnt_d     = '0;
                end
            end
            REQ: begin
                if (bus.ex_startAck) begin
                    ex_start_d = 1'b0;
                    state_d    = REL;
                end
            end
            REL: begin
                // read is issued on entry to FETCH so data lands during LOAD
                if (!bus.ex_startAck) begin
                    state_d   = FETCH;
                    src_en_d  = 1'b1;
                    src_adr_d = cnt_q;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                m_data_d  = bus.src_data;
                m_valid_d = 1'b1;
                m_last_d  = (cnt_q == IN_AW'(IN_WORDS - 1));
                src_en_d  = 1'b0;
                state_d   = SEND;
            end
            SEND: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        state_d   = RECV;
                        s_ready_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        state_d   = FETCH;
                        src_en_d  = 1'b1;
                        src_adr_d = cnt_q + 1'b1;
                    end
                end
            end
            RECV: begin
                if (bus.s_valid && s_ready_q) begin
                    res_we_d   = 1'b1;
                    res_adr_d  = rcnt_q;
                    res_data_d = bus.s_data;
                    if (rcnt_q == OUT_AW'(OUT_WORDS - 1)) begin
                        // final expected word; last flag must accompany it
                        s_ready_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = FIN;
                        if (!bus.s_last) begin
                            err_last_d = 1'b1;
                        end
                    end else if (bus.s_last) begin
                        // stream ended early; keep the word, flag and finish
                        s_ready_d  = 1'b0;
                        done_d     = 1'b1;
                        err_last_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rcnt_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_last_q <= 1'b0;
            ex_start_q <= 1'b0;
            src_en_q   <= 1'b0;
            src_adr_q  <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            s_ready_q  <= 1'b0;
            res_we_q   <= 1'b0;
            res_adr_q  <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_last_q <= err_last_d;
            ex_start_q <= ex_start_d;
            src_en_q   <= src_en_d;
            src_adr_q  <= src_adr_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            s_ready_q  <= s_ready_d;
            res_we_q   <= res_we_d;
            res_adr_q  <= res_adr_d;
            res_data_q <= res_data_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_last     = err_last_q;
    assign bus.ex_start = ex_start_q;
    assign bus.src_en   = src_en_q;
    assign bus.src_adr  = src_adr_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_last   = m_last_q;
    assign bus.s_ready  = s_ready_q;
    assign bus.res_we   = res_we_q;
    assign bus.res_adr  = res_adr_q;
    assign bus.res_data = res_data_q;

endmodule

// File: doc/axis_host_driver.md
Name: axis_host_driver

Overview:
- Host-side counterpart of the accelerator's AXI-Stream interface block.
- On `go`, runs one full transaction against the accelerator:
  - performs the ex_start/ex_startAck start handshake;
  - streams IN_WORDS input words, read from a local synchronous source buffer, out of its AXIS master port;
  - collects OUT_WORDS result words from its AXIS slave port into a result-store write port.
- Sits between the image/weight staging memory and the accelerator's stream interface. Used both as the system-level feeder and as a reusable bench driver.

Parameters:
- DATA_W, 32, stream and memory data width.
- IN_WORDS, 8, words sent per transaction (≥2).
- OUT_WORDS, 4, words expected back per transaction (≥2).
- IN_AW, 3, source address width, clog2(IN_WORDS).
- OUT_AW, 2, result address width, clog2(OUT_WORDS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  start request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transaction ends.
- err_last  out  1  sticky; set on a last-flag mismatch; cleared by reset or by accepted go.
- ex_start  out  1  start request to accelerator.
- ex_startAck  in  1  start acknowledge from accelerator.
- src_en  out  1  source memory read enable.
- src_adr  out  IN_AW  source read address.
- src_data  in  DATA_W  source read data, valid 1 cycle after src_en.
- m_data  out  DATA_W  AXIS master data.
- m_valid  out  1  AXIS master valid.
- m_last  out  1  AXIS master last.
- m_ready  in  1  AXIS master ready.
- s_data  in  DATA_W  AXIS slave data.
- s_valid  in  1  AXIS slave valid.
- s_last  in  1  AXIS slave last.
- s_ready  out  1  AXIS slave ready.
- res_we  out  1  result write strobe.
- res_adr  out  OUT_AW  result write address.
- res_data  out  DATA_W  result write data.

Behaviour:
- Reset (async, rst=1):
  - FSM returns to IDLE immediately, mid-operation included.
  - All outputs go to 0; counters cnt and rcnt go to 0.
  - No partial transfer is resumed after reset.
- All outputs are registered.
- FSM states: IDLE, REQ, REL, FETCH, LOAD, SEND, RECV, FIN.
  - IDLE:
    - go=1 → REQ, ex_start<=1, err_last<=0, cnt<=0, rcnt<=0.
    - go while not in IDLE is ignored.
  - REQ: hold ex_start=1 until ex_startAck=1; then ex_start<=0 → REL.
  - REL: wait for ex_startAck=0 → FETCH. If ack is already low, REL lasts exactly one cycle.
  - FETCH: src_en<=1, src_adr<=cnt for one cycle → LOAD.
  - LOAD:
    - m_data<=src_data, m_valid<=1, m_last<=(cnt==IN_WORDS-1), src_en<=0 → SEND.
  - SEND:
    - Hold m_data, m_valid and m_last stable until m_valid&m_ready. Never retract valid.
    - On the handshake cycle: m_valid<=0, m_last<=0.
    - If the beat was last → RECV with s_ready<=1. Otherwise cnt<=cnt+1 → FETCH.
    - Minimum beat spacing is 3 cycles when m_ready is held high.
  - RECV: s_ready=1. On each s_valid&s_ready, the next cycle drives res_we=1, res_adr=rcnt, res_data=s_data, and rcnt increments.
    - Normal end: rcnt==OUT_WORDS-1 at the handshake → s_ready<=0 → FIN. err_last<=1 if s_last=0 on that beat.
    - Early last: s_last=1 with rcnt<OUT_WORDS-1 → err_last<=1, s_ready<=0 → FIN. The received word is still written.
  - FIN: done=1 for one cycle → IDLE.
- res_we is a one-cycle pulse per accepted beat. res_adr counts 0..OUT_WORDS-1 and never wraps within a transaction.
- s_valid outside RECV is ignored; s_ready=0 there.
- Simultaneous go and rst: rst wins.
- Latency with m_ready=1, ack returned 2 cycles after ex_start, and s_valid=1 continuously:
  - go to first m_valid: 1+3+1+2 cycles.
  - go to done: deterministic; the bench computes the exact expected value from the state sequence above.

Test Plan:
- Nominal: src[i]=i+1, m_ready=1, ack pulse, 4 results 13..16 with last on the 4th → m_data sequence 1..8 with m_last only on 8; res writes adr 0..3 with data 13..16; one done pulse; err_last=0.
- Backpressure: m_ready toggles 0/1 every cycle and is held low 5 cycles on beat 3 → m_data=3 is held stable with m_valid high throughout; no beat lost or duplicated.
- Slow ack: ex_startAck rises 10 cycles after ex_start and stays high 6 cycles → ex_start drops the cycle after ack rises; the first FETCH occurs only after ack falls.
- Early last: s_last=1 on the 2nd result beat (data 14) → res writes adr 0,1 only; err_last=1; done pulses; busy=0 after.
- Missing last: 4 results, none with s_last → 4 writes, err_last=1; the next go clears err_last.
- Reset mid-SEND: assert rst during beat 5 → all outputs 0 immediately; a subsequent go restarts from src_adr=0 and completes the nominal sequence.
